// File: rtl/xmit_prio_scheduler.sv
// xmit_prio_scheduler: picks hi/lo frames (bounded lo starvation), streams bytes with SOF/EOF, enforces IFG
module xmit_prio_scheduler #(
    parameter int LEN_W       = 12,
    parameter int MAX_LO_SKIP = 4,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hi_ctrl_empty,
    input  logic [23:0] hi_ctrl_in,
    output logic        hi_ctrl_rd,
    input  logic [7:0]  hi_data_in,
    output logic        hi_data_rd,
    input  logic        lo_ctrl_empty,
    input  logic [23:0] lo_ctrl_in,
    output logic        lo_ctrl_rd,
    input  logic [7:0]  lo_data_in,
    output logic        lo_data_rd,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        tx_hi,
    output logic        drop_pulse
);
    localparam int SKIP_W = MAX_LO_SKIP > 0 ? $clog2(MAX_LO_SKIP + 1) : 1;
    localparam int GAP_W  = $clog2(IFG_CYCLES + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_LO_SKIP);
    localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(IFG_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

    state_t            state;
    logic              sel_hi;
    logic              first;
    logic [SKIP_W-1:0] skip_cnt;
    logic [LEN_W-1:0]  remaining;
    logic [GAP_W-1:0]  gap_cnt;
    logic [LEN_W-1:0]  len;
    logic              pick_hi;
    logic              load;
    logic              unused_ctrl;

    assign len         = sel_hi ? hi_ctrl_in[LEN_W-1:0] : lo_ctrl_in[LEN_W-1:0];
    assign pick_hi     = !hi_ctrl_empty && (lo_ctrl_empty || skip_cnt < SKIP_MAX);
    assign load        = state == XFER && (!tx_valid || tx_ready) && remaining != '0;
    assign unused_ctrl = ^{hi_ctrl_in[23:LEN_W], lo_ctrl_in[23:LEN_W]};

    // Data pops are combinational with the load so the show-ahead head advances every cycle
    assign hi_ctrl_rd = state == GRANT && sel_hi;
    assign lo_ctrl_rd = state == GRANT && !sel_hi;
    assign hi_data_rd = load && sel_hi;
    assign lo_data_rd = load && !sel_hi;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel_hi     <= 1'b0;
            first      <= 1'b0;
            skip_cnt   <= '0;
            remaining  <= '0;
            gap_cnt    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
            tx_hi      <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                IDLE: if (!hi_ctrl_empty || !lo_ctrl_empty) begin
                    state    <= GRANT;
                    sel_hi   <= pick_hi;
                    skip_cnt <= pick_hi ? (lo_ctrl_empty ? '0 : skip_cnt + 1'b1) : '0;
                end
                GRANT: begin
                    remaining  <= len;
                    tx_hi      <= sel_hi;
                    first      <= 1'b1;
                    drop_pulse <= len == '0;
                    state      <= len == '0 ? IDLE : XFER;
                end
                XFER: if (load) begin
                    tx_data   <= sel_hi ? hi_data_in : lo_data_in;
                    tx_valid  <= 1'b1;
                    tx_sof    <= first;
                    tx_eof    <= remaining == LEN_W'(1);
                    remaining <= remaining - 1'b1;
                    first     <= 1'b0;
                end else if (tx_valid && tx_ready) begin
                    tx_valid <= 1'b0;
                    tx_sof   <= 1'b0;
                    tx_eof   <= 1'b0;
                    if (tx_eof) begin
                        state   <= GAP;
                        gap_cnt <= GAP_INIT;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
